// File: rtl/deint_pkg.sv
// Shared types for the deinterlacer read side.
// Line length, repeat modes, reader states, mode decode.
package deint_pkg;

  localparam int LINE_LEN = 640;

  typedef enum logic [1:0] {
    ONCE   = 2'b00,
    TWICE  = 2'b01,
    THRICE = 2'b10,
    RSVD   = 2'b11
  } repeat_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    STREAM,
    DRAIN,
    RELEASE
  } lrr_state_e;

  // Reserved mode falls back to a single pass.
  function automatic logic [1:0] mode_passes(
    input repeat_mode_e m
  );
    logic [1:0] n;
    n = 2'd1;
    case (m)
      TWICE:   n = 2'd2;
      THRICE:  n = 2'd3;
      default: n = 2'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/line_repeat_reader_if.sv
// Pixel stream bundle with line markers.
// Valid/ready handshake, master drives pixels.
interface line_repeat_reader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              sol;
  logic              eol;
  logic              last_rep;

  modport master (
    output data, valid, sol, eol, last_rep,
    input  ready
  );

  modport slave (
    input  data, valid, sol, eol, last_rep,
    output ready
  );
endinterface

// File: rtl/pix_out_fifo.sv
// Small synchronous FIFO for tagged pixels.
// Push when full and pop when empty are ignored.
module pix_out_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OW-1:0]    occupancy,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (occupancy == '0);
  assign full    = (occupancy == OW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage, pointers and fill level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/line_repeat_reader.sv
// Reads a full line from the line buffer and
// replays it 1..3 times as a marked pixel stream.
module line_repeat_reader
  import deint_pkg::*;
#(
  parameter int LINE_LEN    = deint_pkg::LINE_LEN,
  parameter int DATA_W      = 8,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   buf_full,
  output logic                   buf_rd_req,
  input  logic [DATA_W-1:0]      buf_q,
  input  logic [1:0]             repeat_mode,
  line_repeat_reader_if.master   out,
  output logic                   busy
);

  localparam int RW = $clog2(LINE_LEN + 1);
  localparam int OW = $clog2(OFIFO_DEPTH + 1);
  localparam int CW = OW + 1;
  localparam int FW = DATA_W + 3;

  lrr_state_e     state;
  logic           prime_cnt;
  logic [RW-1:0]  req_cnt;
  logic [1:0]     passes_left;

  // Request pipe: valid, capture, eol tag.
  logic           v1, c1, e1;
  logic           v2, c2, e2;

  logic [1:0]     inflight;
  logic [OW-1:0]  occupancy;
  logic           fifo_empty;
  logic           fifo_full;
  logic           credit_ok;
  logic           rd_req;
  logic           prime_fire;
  logic           drain_done;
  logic           push;
  logic           pop;
  logic [FW-1:0]  push_data;
  logic [FW-1:0]  head;

  assign inflight   = {1'b0, v1} + {1'b0, v2};
  assign credit_ok  = (CW'(occupancy) + CW'(inflight))
                      < CW'(OFIFO_DEPTH);
  assign rd_req     = (state == STREAM) && credit_ok
                      && (req_cnt < RW'(LINE_LEN));
  assign prime_fire = (state == PRIME) && prime_cnt
                      && !fifo_full;
  // The wrap-only return never needs capturing, so
  // the pass may end while it is still on the bus.
  assign drain_done = !v1;

  assign push      = prime_fire || (v2 && c2);
  assign push_data = {buf_q,
                      prime_fire,
                      v2 && c2 && e2,
                      passes_left == 2'd1};

  assign pop        = out.valid && out.ready;
  assign out.valid  = !fifo_empty;
  assign out.data   = fifo_empty ? '0 : head[FW-1:3];
  assign out.sol    = !fifo_empty && head[2];
  assign out.eol    = !fifo_empty && head[1];
  assign out.last_rep = !fifo_empty && head[0];

  assign buf_rd_req = rd_req;
  assign busy       = (state != IDLE);

  pix_out_fifo #(
    .WIDTH (FW),
    .DEPTH (OFIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .occupancy (occupancy),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Tracks outstanding buffer reads and their tags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      c1 <= 1'b0;
      e1 <= 1'b0;
      v2 <= 1'b0;
      c2 <= 1'b0;
      e2 <= 1'b0;
    end else begin
      v1 <= rd_req;
      c1 <= rd_req && (req_cnt != RW'(LINE_LEN - 1));
      e1 <= rd_req && (req_cnt == RW'(LINE_LEN - 2));
      v2 <= v1;
      c2 <= c1;
      e2 <= e1;
    end
  end

  // Line/pass sequencing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prime_cnt   <= 1'b0;
      req_cnt     <= '0;
      passes_left <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (buf_full) begin
            passes_left <= mode_passes(
                             repeat_mode_e'(repeat_mode));
            prime_cnt   <= 1'b0;
            state       <= PRIME;
          end
        end
        PRIME: begin
          if (!prime_cnt) begin
            prime_cnt <= 1'b1;
          end else if (!fifo_full) begin
            req_cnt <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (rd_req) begin
            req_cnt <= req_cnt + RW'(1);
            if (req_cnt == RW'(LINE_LEN - 1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            passes_left <= passes_left - 2'd1;
            prime_cnt   <= 1'b0;
            state <= (passes_left == 2'd1) ? RELEASE : PRIME;
          end
        end
        RELEASE: begin
          if (fifo_empty && !buf_full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_repeat_reader.sv
// Directed bench for line_repeat_reader with a
// behavioural 640-entry line buffer model.
module tb_line_repeat_reader;

  localparam int LL = 640;

  logic       clock = 1'b0;
  logic       reset;
  logic       buf_full;
  logic       buf_rd_req;
  logic [7:0] buf_q;
  logic [1:0] repeat_mode;
  logic       busy;

  line_repeat_reader_if #(.DATA_W(8)) out_if ();

  line_repeat_reader #(
    .LINE_LEN    (LL),
    .DATA_W      (8),
    .OFIFO_DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .buf_full    (buf_full),
    .buf_rd_req  (buf_rd_req),
    .buf_q       (buf_q),
    .repeat_mode (repeat_mode),
    .out         (out_if),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;

  // Buffer model: mem[i] = i[7:0], 2-cycle read latency.
  logic [9:0] bptr;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bptr  <= '0;
      buf_q <= '0;
    end else begin
      if (buf_rd_req)
        bptr <= (bptr == 10'(LL - 1)) ? 10'd0 : bptr + 10'd1;
      buf_q <= bptr[7:0];
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  bit rand_ready = 1'b0;
  bit ready_lvl  = 1'b1;
  always @(posedge clock) begin
    #1;
    if (rand_ready) out_if.ready = ($urandom_range(0, 99) < 30);
    else            out_if.ready = ready_lvl;
  end

  logic [7:0] lg_data [4096];
  bit         lg_sol  [4096];
  bit         lg_eol  [4096];
  bit         lg_last [4096];
  int         lg_cyc  [4096];
  int         log_n = 0;
  int         req_n = 0;
  bit         occ_viol = 1'b0;

  // Log accepted pixels and requests mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_if.valid && out_if.ready && log_n < 4096) begin
        lg_data[log_n] = out_if.data;
        lg_sol[log_n]  = out_if.sol;
        lg_eol[log_n]  = out_if.eol;
        lg_last[log_n] = out_if.last_rep;
        lg_cyc[log_n]  = cyc;
        log_n++;
      end
      if (buf_rd_req) req_n++;
      if (int'(dut.occupancy) + int'(dut.inflight) > 4)
        occ_viol = 1'b1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: sim still running");
    $fatal(1, "timeout");
  end

  task automatic clear_log();
    log_n = 0;
    req_n = 0;
    occ_viol = 1'b0;
  endtask

  task automatic start_line(input logic [1:0] mode);
    clear_log();
    @(posedge clock); #1;
    repeat_mode = mode;
    buf_full = 1'b1;
    c0 = cyc;
  endtask

  task automatic drop_full();
    @(posedge clock); #1;
    buf_full = 1'b0;
  endtask

  task automatic wait_pixels(input int n, input int budget,
                             output bit ok);
    int k;
    k = 0;
    while (log_n < n && k < budget) begin
      @(posedge clock); #1;
      k++;
    end
    ok = (log_n >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(posedge clock); #1;
      k++;
    end
    ok = !busy;
    repeat (10) @(posedge clock);
    #1;
  endtask

  // Counts logged pixels that differ from the model.
  function automatic int seq_errors(input int passes);
    int bad;
    bad = 0;
    for (int i = 0; i < log_n; i++) begin
      int k;
      int p;
      logic [7:0] ed;
      k  = i % LL;
      p  = i / LL;
      ed = k[7:0];
      if (lg_data[i] !== ed ||
          lg_sol[i]  !== (k == 0) ||
          lg_eol[i]  !== (k == LL - 1) ||
          lg_last[i] !== (p == passes - 1))
        bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    buf_full = 1'b0;
    repeat_mode = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_if.valid !== 1'b0 || out_if.data !== 8'd0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%0d want 0 0",
               out_if.valid, out_if.data);
    end
    checks++;
    if (busy !== 1'b0 || buf_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b req=%b want 0 0",
               busy, buf_rd_req);
    end
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || out_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b valid=%b want 0 0",
               busy, out_if.valid);
    end
  endtask

  task automatic test_mode0();
    bit ok;
    int bad;
    rand_ready = 1'b0;
    ready_lvl = 1'b1;
    start_line(2'b00);
    drop_full();
    wait_pixels(LL, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mode0_timeout: got %0d want %0d", log_n, LL);
    end
    wait_idle(200, ok);
    checks++;
    if (log_n != LL || !ok) begin
      errors++;
      $display("FAIL mode0_count: got %0d idle=%b want %0d 1",
               log_n, ok, LL);
    end
    bad = seq_errors(1);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mode0_seq: %0d bad pixels want 0", bad);
    end
    checks++;
    if (lg_cyc[0] != c0 + 3) begin
      errors++;
      $display("FAIL mode0_latency: first at %0d want %0d",
               lg_cyc[0] - c0, 3);
    end
    checks++;
    if (req_n != LL) begin
      errors++;
      $display("FAIL mode0_reqs: got %0d want %0d", req_n, LL);
    end
  endtask

  task automatic test_mode1_midchange();
    bit ok;
    int bad;
    int gaps;
    rand_ready = 1'b0;
    ready_lvl = 1'b1;
    start_line(2'b01);
    drop_full();
    repeat (100) @(posedge clock);
    #1;
    repeat_mode = 2'b10;
    wait_pixels(2 * LL, 4000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mode1_timeout: got %0d want %0d",
               log_n, 2 * LL);
    end
    wait_idle(200, ok);
    repeat_mode = 2'b00;
    checks++;
    if (log_n != 2 * LL || !ok) begin
      errors++;
      $display("FAIL mode1_count: got %0d idle=%b want %0d 1",
               log_n, ok, 2 * LL);
    end
    bad = seq_errors(2);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mode1_seq: %0d bad pixels want 0", bad);
    end
    checks++;
    if (lg_cyc[LL] - lg_cyc[0] != LL + 4) begin
      errors++;
      $display("FAIL mode1_pass_period: got %0d want %0d",
               lg_cyc[LL] - lg_cyc[0], LL + 4);
    end
    gaps = 0;
    for (int i = 2; i < 2 * LL; i++) begin
      if (i % LL > 1 && lg_cyc[i] - lg_cyc[i-1] != 1) gaps++;
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL mode1_rate: %0d stalls want 0", gaps);
    end
    checks++;
    if (req_n != 2 * LL) begin
      errors++;
      $display("FAIL mode1_reqs: got %0d want %0d",
               req_n, 2 * LL);
    end
  endtask

  task automatic test_mode2_random();
    bit ok;
    int bad;
    rand_ready = 1'b1;
    start_line(2'b10);
    drop_full();
    wait_pixels(3 * LL, 40000, ok);
    rand_ready = 1'b0;
    ready_lvl = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mode2_timeout: got %0d want %0d",
               log_n, 3 * LL);
    end
    wait_idle(200, ok);
    checks++;
    if (log_n != 3 * LL || !ok) begin
      errors++;
      $display("FAIL mode2_count: got %0d idle=%b want %0d 1",
               log_n, ok, 3 * LL);
    end
    bad = seq_errors(3);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mode2_seq: %0d bad pixels want 0", bad);
    end
    checks++;
    if (req_n != 3 * LL) begin
      errors++;
      $display("FAIL mode2_reqs: got %0d want %0d",
               req_n, 3 * LL);
    end
    checks++;
    if (occ_viol) begin
      errors++;
      $display("FAIL mode2_credit: occ+inflight=%0d want <=4",
               5);
    end
  endtask

  task automatic test_mode3();
    bit ok;
    int bad;
    rand_ready = 1'b0;
    ready_lvl = 1'b1;
    start_line(2'b11);
    drop_full();
    wait_pixels(LL, 3000, ok);
    wait_idle(200, ok);
    checks++;
    if (log_n != LL || !ok) begin
      errors++;
      $display("FAIL mode3_count: got %0d idle=%b want %0d 1",
               log_n, ok, LL);
    end
    bad = seq_errors(1);
    checks++;
    if (bad != 0 || lg_cyc[0] != c0 + 3 || req_n != LL) begin
      errors++;
      $display("FAIL mode3_seq: bad=%0d lat=%0d reqs=%0d want 0 3 %0d",
               bad, lg_cyc[0] - c0, req_n, LL);
    end
  endtask

  task automatic test_hold_full();
    bit ok;
    int bad;
    rand_ready = 1'b0;
    ready_lvl = 1'b1;
    start_line(2'b00);
    wait_pixels(LL, 3000, ok);
    repeat (50) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_busy: busy=%b want 1", busy);
    end
    checks++;
    if (log_n != LL || req_n != LL) begin
      errors++;
      $display("FAIL hold_no_retrigger: pix=%0d reqs=%0d want %0d",
               log_n, req_n, LL);
    end
    buf_full = 1'b0;
    wait_idle(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_release: busy=%b want 0", busy);
    end
    start_line(2'b00);
    drop_full();
    wait_pixels(LL, 3000, ok);
    wait_idle(200, ok);
    bad = seq_errors(1);
    checks++;
    if (log_n != LL || bad != 0) begin
      errors++;
      $display("FAIL hold_next_line: pix=%0d bad=%0d want %0d 0",
               log_n, bad, LL);
    end
  endtask

  task automatic test_reset_midline();
    bit ok;
    int bad;
    rand_ready = 1'b0;
    ready_lvl = 1'b1;
    start_line(2'b01);
    drop_full();
    wait_pixels(300, 3000, ok);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_if.valid !== 1'b0 || out_if.sol !== 1'b0 ||
        out_if.eol !== 1'b0 || out_if.last_rep !== 1'b0 ||
        out_if.data !== 8'd0) begin
      errors++;
      $display("FAIL midreset_out: v=%b s=%b e=%b l=%b d=%0d want 0",
               out_if.valid, out_if.sol, out_if.eol,
               out_if.last_rep, out_if.data);
    end
    checks++;
    if (busy !== 1'b0 || buf_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: busy=%b req=%b want 0 0",
               busy, buf_rd_req);
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    clear_log();
    repeat (20) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || log_n != 0 || req_n != 0) begin
      errors++;
      $display("FAIL midreset_quiet: busy=%b pix=%0d reqs=%0d want 0",
               busy, log_n, req_n);
    end
    start_line(2'b00);
    drop_full();
    wait_pixels(LL, 3000, ok);
    wait_idle(200, ok);
    bad = seq_errors(1);
    checks++;
    if (log_n != LL || bad != 0 || lg_cyc[0] != c0 + 3) begin
      errors++;
      $display("FAIL midreset_clean: pix=%0d bad=%0d lat=%0d want %0d 0 3",
               log_n, bad, lg_cyc[0] - c0, LL);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1_midchange();
    test_mode2_random();
    test_mode3();
    test_hold_full();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
